// File: rtl/tile_engine_pkg.sv
// +----------------------------------------------------------------------------+
// | tile_engine_pkg : shared modes, latencies and fixed-point helper            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package tile_engine_pkg;

    typedef enum logic [1:0] {
        MODE_MAC = 2'b00,
        MODE_EWM = 2'b01,
        MODE_EWA = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    localparam int LAT_EW = 1;

    function automatic int mac_latency(input int num_arrays);
        return num_arrays;
    endfunction

    // Operands arrive sign-extended to 64 bits; callers truncate to their accumulator width.
    function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int frac);
        return (a * b) >>> frac;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_chain_engine_pe_array.sv
// +----------------------------------------------------------------------------+
// | tile_pe_array : one registered TILE_SIZE x TILE_SIZE processing array       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_pe_array
    import tile_engine_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   en,
    input  mode_e                                                  mode,
    input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]    a,
    input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]    b,
    input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]     acc_in,
    output logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]     r
);

    logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] w_nxt;

    always_comb begin
        w_nxt = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            for (int j = 0; j < TILE_SIZE; j++) begin
                case (mode)
                    MODE_MAC: w_nxt[i][j] = acc_in[i][j] + ACC_WIDTH'(fx_mul(
                                  64'($signed(a[i][j])), 64'($signed(b[i][j])), FRAC_BITS));
                    MODE_EWM: w_nxt[i][j] = ACC_WIDTH'(fx_mul(
                                  64'($signed(a[i][j])), 64'($signed(b[i][j])), FRAC_BITS));
                    MODE_EWA: w_nxt[i][j] = ACC_WIDTH'($signed(a[i][j]))
                                          + ACC_WIDTH'($signed(b[i][j]));
                    default:  w_nxt[i][j] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (en) begin
            r <= w_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tile_chain_engine.sv
// +----------------------------------------------------------------------------+
// | tile_chain_engine : chained MAC / parallel element-wise PE array engine     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_chain_engine
    import tile_engine_pkg::*;
#(
    parameter int NUM_ARRAYS = 4,
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int MAX_COLS   = 64,
    localparam int CNT_W     = $clog2(MAX_COLS + 1)
) (
    input  logic                                                                  clk,
    input  logic                                                                  rst_n,
    input  logic                                                                  in_valid,
    output logic                                                                  in_ready,
    input  logic [1:0]                                                            in_mode,
    input  logic [CNT_W-1:0]                                                      cols_per_tile,
    input  logic [NUM_ARRAYS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]   a_in,
    input  logic [NUM_ARRAYS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0]   b_in,
    output logic                                                                  out_valid,
    input  logic                                                                  out_ready,
    output logic [NUM_ARRAYS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]    result_out,
    output logic                                                                  tile_done,
    output logic                                                                  busy,
    output logic                                                                  err_mode
);

    localparam int LAT_MAC = mac_latency(NUM_ARRAYS);

    typedef logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_d_t;
    typedef logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]  tile_a_t;

    logic [LAT_MAC-1:0] r_mac_v;
    logic               r_ew_v;
    logic               r_err;
    mode_e              r_cur_mode;
    logic [CNT_W-1:0]   r_col_cnt;
    logic [CNT_W-1:0]   r_tile_len;

    logic               w_adv;
    logic               w_acc;
    logic               w_mac_acc;
    logic               w_ew_acc;
    logic               w_ill_acc;
    mode_e              w_mode;
    mode_e              w_pe_mode;
    logic [CNT_W-1:0]   w_len_in;
    tile_a_t            w_r [NUM_ARRAYS];

    assign w_mode    = mode_e'(in_mode);
    assign out_valid = r_mac_v[LAT_MAC-1] | r_ew_v;
    assign busy      = (|r_mac_v) | r_ew_v;
    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv && !(busy && (w_mode != r_cur_mode));
    assign w_acc     = in_valid && in_ready;
    assign w_mac_acc = w_acc && (w_mode == MODE_MAC);
    assign w_ew_acc  = w_acc && ((w_mode == MODE_EWM) || (w_mode == MODE_EWA));
    assign w_ill_acc = w_acc && (w_mode == MODE_ILL);
    assign w_pe_mode = w_ew_acc ? w_mode : MODE_MAC;
    assign w_len_in  = (cols_per_tile == '0) ? CNT_W'(1) : cols_per_tile;
    assign err_mode  = r_err;
    assign tile_done = r_mac_v[LAT_MAC-1] && (r_col_cnt == r_tile_len - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_v    <= '0;
            r_ew_v     <= 1'b0;
            r_err      <= 1'b0;
            r_cur_mode <= MODE_MAC;
            r_col_cnt  <= '0;
            r_tile_len <= CNT_W'(1);
        end else begin
            r_err <= w_ill_acc;
            if (w_adv) begin
                r_mac_v <= {r_mac_v[LAT_MAC-2:0], w_mac_acc};
                r_ew_v  <= w_ew_acc;
            end
            if (w_mac_acc || w_ew_acc) begin
                r_cur_mode <= w_mode;
            end
            if (w_mac_acc && (r_col_cnt == '0)) begin
                r_tile_len <= w_len_in;
            end
            // Leaving MAC restarts tile counting; a switch only happens once drained.
            if (w_ew_acc && (r_cur_mode == MODE_MAC)) begin
                r_col_cnt <= '0;
            end else if (r_mac_v[LAT_MAC-1] && out_ready) begin
                r_col_cnt <= tile_done ? '0 : r_col_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_ARRAYS; k++) begin : g_arr
        tile_d_t w_a_mac;
        tile_d_t w_b_mac;
        tile_a_t w_acc_in;

        if (k == 0) begin : g_head
            assign w_a_mac  = a_in[0];
            assign w_b_mac  = b_in[0];
            assign w_acc_in = '0;
        end else begin : g_skew
            // Array k sees its operands k beats late so it lines up with array k-1's sum.
            tile_d_t [k-1:0] r_skw_a;
            tile_d_t [k-1:0] r_skw_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_skw_a <= '0;
                    r_skw_b <= '0;
                end else if (w_adv) begin
                    r_skw_a[0] <= a_in[k];
                    r_skw_b[0] <= b_in[k];
                    for (int j = 1; j < k; j++) begin
                        r_skw_a[j] <= r_skw_a[j-1];
                        r_skw_b[j] <= r_skw_b[j-1];
                    end
                end
            end

            assign w_a_mac  = r_skw_a[k-1];
            assign w_b_mac  = r_skw_b[k-1];
            assign w_acc_in = w_r[k-1];
        end

        tile_pe_array #(
            .TILE_SIZE  (TILE_SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_pe (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (w_adv),
            .mode   (w_pe_mode),
            .a      (w_ew_acc ? a_in[k] : w_a_mac),
            .b      (w_ew_acc ? b_in[k] : w_b_mac),
            .acc_in (w_acc_in),
            .r      (w_r[k])
        );

        assign result_out[k] = (r_ew_v || (k == NUM_ARRAYS - 1)) ? w_r[k] : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_tile_chain_engine.sv
// +----------------------------------------------------------------------------+
// | tb_tile_chain_engine : randomized bench with a beat-level reference model   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tile_chain_engine;

    localparam int N  = 4;
    localparam int T  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int FB = 8;
    localparam int CW = 7;

    typedef logic [N-1:0][T-1:0][T-1:0][DW-1:0] dat_t;
    typedef logic [N-1:0][T-1:0][T-1:0][AW-1:0] res_t;
    typedef struct packed {
        int   age;
        int   lat;
        bit   mac;
        res_t res;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_mode = 2'b00;
    logic [CW-1:0] cols_per_tile = '0;
    dat_t          a_in = '0;
    dat_t          b_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    res_t          result_out;
    logic          tile_done;
    logic          busy;
    logic          err_mode;

    tile_chain_engine #(
        .NUM_ARRAYS(N), .TILE_SIZE(T), .DATA_WIDTH(DW),
        .ACC_WIDTH(AW), .FRAC_BITS(FB), .MAX_COLS(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .cols_per_tile(cols_per_tile), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .tile_done(tile_done), .busy(busy), .err_mode(err_mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit hold_low = 1'b0;
    bit rnd_rdy  = 1'b0;

    // reference model state
    beat_t q[$];
    int    m_cur = 0;
    int    m_col = 0;
    int    m_len = 1;
    bit    m_err = 1'b0;

    // observation counters for hand-computed expectations
    int          mon_cnt, mon_ov_cnt, mon_err, mon_first_acc, mon_first_ov, mon_acc_busy;
    logic [63:0] mon_td;
    logic [31:0] mon_last0, mon_last3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic res_t model(input logic [1:0] m, input dat_t a, input dat_t b);
        res_t   r;
        int     s;
        longint sa, sb;
        int     p;
        r = '0;
        for (int i = 0; i < T; i++) begin
            for (int j = 0; j < T; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    sa = $signed(a[k][i][j]);
                    sb = $signed(b[k][i][j]);
                    p  = int'((sa * sb) >>> FB);
                    if (m == 2'd0)      s = s + p;
                    else if (m == 2'd1) r[k][i][j] = p;
                    else                r[k][i][j] = int'(sa + sb);
                end
                if (m == 2'd0) r[N-1][i][j] = s;
            end
        end
        return r;
    endfunction

    task automatic mon_clear();
        mon_cnt = 0; mon_ov_cnt = 0; mon_err = 0; mon_first_acc = -1;
        mon_first_ov = -1; mon_acc_busy = -1; mon_td = '0; mon_last0 = '0; mon_last3 = '0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = hold_low ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    bit    e_ov, e_busy, e_adv, e_ir, e_td, e_acc, e_hs, e_err_nxt;
    beat_t nb;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {59'd0, out_valid, busy, tile_done, err_mode, (result_out != '0)}, 64'd0);
            q.delete();
            m_cur = 0; m_col = 0; m_len = 1; m_err = 1'b0;
        end else begin
            e_ov   = (q.size() > 0) && (q[0].age >= q[0].lat);
            e_busy = (q.size() > 0);
            e_adv  = !e_ov || out_ready;
            e_ir   = e_adv && !(e_busy && (int'(in_mode) != m_cur));
            chk("out_valid", out_valid, e_ov);
            chk("busy", busy, e_busy);
            chk("in_ready", in_ready, e_ir);
            chk("err_mode", err_mode, m_err);
            e_td = e_ov && q[0].mac && (m_col == m_len - 1);
            chk("tile_done", tile_done, e_td);
            if (e_ov) begin
                n_checks++;
                if (result_out !== q[0].res) begin
                    n_fail++;
                    for (int k = 0; k < N; k++)
                        for (int i = 0; i < T; i++)
                            for (int j = 0; j < T; j++)
                                if (result_out[k][i][j] !== q[0].res[k][i][j]) begin
                                    $display("FAIL result[%0d][%0d][%0d] actual=%0h expected=%0h (cycle %0d)",
                                             k, i, j, result_out[k][i][j], q[0].res[k][i][j], cyc);
                                    k = N; i = T; j = T;
                                end
                end
            end

            // observations for the directed expectations
            if (out_valid) mon_ov_cnt++;
            if (out_valid && mon_first_ov < 0) mon_first_ov = cyc;
            if (in_valid && in_ready && mon_first_acc < 0) mon_first_acc = cyc;
            if (in_valid && in_ready && in_mode == 2'd1) mon_acc_busy = int'(busy);
            if (err_mode) mon_err++;
            if (out_valid && out_ready) begin
                mon_cnt++;
                if (tile_done && mon_cnt <= 64) mon_td[mon_cnt-1] = 1'b1;
                mon_last0 = result_out[0][0][0];
                mon_last3 = result_out[N-1][1][2];
            end

            // advance the model by one clock
            e_acc     = in_valid && e_ir;
            e_hs      = e_ov && out_ready;
            e_err_nxt = e_acc && (in_mode == 2'd3);
            if (e_acc && in_mode == 2'd0 && m_col == 0)
                m_len = (cols_per_tile == 0) ? 1 : int'(cols_per_tile);
            if (e_acc && (in_mode == 2'd1 || in_mode == 2'd2) && m_cur == 0)
                m_col = 0;
            else if (e_hs && q[0].mac)
                m_col = e_td ? 0 : m_col + 1;
            if (e_hs) void'(q.pop_front());
            if (e_adv)
                for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (e_acc && in_mode != 2'd3) begin
                nb.age = 1;
                nb.lat = (in_mode == 2'd0) ? N : 1;
                nb.mac = (in_mode == 2'd0);
                nb.res = model(in_mode, a_in, b_in);
                q.push_back(nb);
                m_cur = int'(in_mode);
            end
            m_err = e_err_nxt;
        end
    end

    task automatic send(input logic [1:0] m, input int cols, input bit rnd,
                        input logic [15:0] av, input logic [15:0] bv);
        bit got;
        in_mode       = m;
        cols_per_tile = CW'(cols);
        for (int k = 0; k < N; k++)
            for (int i = 0; i < T; i++)
                for (int j = 0; j < T; j++) begin
                    a_in[k][i][j] = rnd ? 16'($urandom) : av;
                    b_in[k][i][j] = rnd ? 16'($urandom) : bv;
                end
        in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout actual=no_accept expected=accept (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 1000 && !idle; t++) begin
            @(negedge clk);
            if (!busy && !out_valid) idle = 1'b1;
        end
        if (!idle) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout actual=busy expected=idle (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog actual=running expected=finished (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        mon_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", (result_out != '0), 1'b0);
        rst_n = 1'b1;
        idle_cycles(1);

        // 1: MAC chain of 16 unit-by-two beats
        mon_clear();
        for (int n = 0; n < 16; n++) send(2'd0, 16, 1'b0, 16'h0100, 16'h0200);
        wait_idle();
        chk("t1_latency", mon_first_ov - mon_first_acc, 64'd4);
        chk("t1_beats", mon_cnt, 64'd16);
        chk("t1_tile_done_pos", mon_td, 64'h8000);
        chk("t1_chain_sum", mon_last3, 64'h800);
        chk("t1_slot0_zero", mon_last0, 64'h0);

        // 2: EWA then EWM
        mon_clear();
        send(2'd2, 0, 1'b0, 16'hFFFD, 16'h0005);
        wait_idle();
        chk("t2_ewa_latency", mon_first_ov - mon_first_acc, 64'd1);
        chk("t2_ewa_slot0", mon_last0, 64'd2);
        chk("t2_ewa_slot3", mon_last3, 64'd2);
        mon_clear();
        send(2'd1, 0, 1'b0, 16'h0180, 16'h0200);
        wait_idle();
        chk("t2_ewm_slot0", mon_last0, 64'h300);
        chk("t2_ewm_slot3", mon_last3, 64'h300);

        // 3: backpressure in the middle of a tile
        mon_clear();
        fork
            for (int n = 0; n < 16; n++) send(2'd0, 16, 1'b1, 16'h0, 16'h0);
            begin
                repeat (7) @(posedge clk);
                #1 hold_low = 1'b1;
                repeat (3) @(negedge clk);
                chk("t3_stall_in_ready", in_ready, 1'b0);
                chk("t3_stall_out_valid", out_valid, 1'b1);
                repeat (3) @(posedge clk);
                #1 hold_low = 1'b0;
            end
        join
        wait_idle();
        chk("t3_beats", mon_cnt, 64'd16);
        chk("t3_tile_done_pos", mon_td, 64'h8000);

        // 4: MAC -> EWM switch with MAC beats still in flight
        mon_clear();
        for (int n = 0; n < 3; n++) send(2'd0, 16, 1'b1, 16'h0, 16'h0);
        in_mode  = 2'd1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t4_blocked_in_ready", in_ready, 1'b0);
        chk("t4_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        send(2'd1, 0, 1'b1, 16'h0, 16'h0);
        wait_idle();
        chk("t4_busy_at_ewm_accept", mon_acc_busy, 64'd0);
        chk("t4_beats", mon_cnt, 64'd4);

        // 5: illegal mode, then single-beat tiles
        mon_clear();
        send(2'd3, 0, 1'b1, 16'h0, 16'h0);
        idle_cycles(4);
        chk("t5_err_pulses", mon_err, 64'd1);
        chk("t5_no_out_valid", mon_ov_cnt, 64'd0);
        mon_clear();
        for (int n = 0; n < 5; n++) send(2'd0, 0, 1'b1, 16'h0, 16'h0);
        wait_idle();
        chk("t5_tile_done_pos", mon_td, 64'h1F);

        // 6: reset in the middle of a tile with a result held
        hold_low = 1'b1;
        for (int n = 0; n < 3; n++) send(2'd0, 8, 1'b1, 16'h0, 16'h0);
        idle_cycles(5);
        chk("t6_held_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_tile_done", tile_done, 1'b0);
        chk("t6_rst_result", (result_out != '0), 1'b0);
        hold_low = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(1);
        mon_clear();
        for (int n = 0; n < 6; n++) send(2'd0, 3, 1'b1, 16'h0, 16'h0);
        wait_idle();
        chk("t6_tile_done_after_reset", mon_td, 64'h24);

        // randomized traffic against the model
        rnd_rdy = 1'b1;
        for (int r = 0; r < 60; r++) begin
            int pick, len, cols;
            logic [1:0] m;
            pick = $urandom_range(0, 15);
            m    = (pick < 7) ? 2'd0 : (pick < 11) ? 2'd1 : (pick < 15) ? 2'd2 : 2'd3;
            len  = $urandom_range(1, 8);
            cols = $urandom_range(0, 5);
            for (int n = 0; n < len; n++) begin
                send(m, cols, 1'b1, 16'h0, 16'h0);
                if ($urandom_range(0, 3) == 0) idle_cycles(1);
            end
        end
        wait_idle();
        rnd_rdy = 1'b0;
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
